// File: rtl/pimp_pkg.sv
// Shared types for the program sequencer: state encoding and core address width.
package pimp_pkg;
    localparam int PIMP_ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        RUN,
        FINISH,
        ERR
    } seq_state_t;
endpackage

// File: rtl/sat_counter.sv
// 16-bit up counter with synchronous clear, enable, and a compare flag that
// fires when the next increment would reach the limit.
module sat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] limit,
    output logic [15:0] count,
    output logic        last
);
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
    assign last  = ((count_q + 16'd1) == limit);
endmodule

// File: rtl/prog_sequencer.sv
// Launches a fixed list of programs on the core back-to-back, reporting each
// program's RUN-cycle count and aborting with a sticky flag on timeout.
module prog_sequencer
    import pimp_pkg::*;
#(
    parameter int                               NUM_PROGS    = 3,
    parameter logic [NUM_PROGS*PIMP_ADDR_W-1:0] START_ADDRS  = {8'd128, 8'd64, 8'd0},
    parameter int                               START_CYCLES = 2,
    parameter logic [15:0]                      TIMEOUT      = 16'd4000
) (
    input  logic                                             CLK,
    input  logic                                             Reset,
    input  logic                                             Go,
    input  logic                                             CoreDone,
    output logic                                             Start,
    output logic [PIMP_ADDR_W-1:0]                           StartAddr,
    output logic                                             Busy,
    output logic [(NUM_PROGS > 1 ? $clog2(NUM_PROGS) : 1)-1:0] ProgIdx,
    output logic [15:0]                                      CycleCount,
    output logic                                             CountValid,
    output logic                                             AllDone,
    output logic                                             TimedOut
);
    localparam int                IDX_W    = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PROGS - 1);

    seq_state_t             state_q, state_d;
    logic [IDX_W-1:0]       prog_idx_q, prog_idx_d;
    logic [15:0]            cycle_count_q, cycle_count_d;
    logic                   count_valid_q, count_valid_d;
    logic                   all_done_q, all_done_d;
    logic                   timed_out_q, timed_out_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic [PIMP_ADDR_W-1:0] start_addr_q, start_addr_d;

    logic [15:0] launch_count, run_count;
    logic        launch_last, run_last;

    sat_counter u_launch_cnt (
        .clk   (CLK),
        .rst   (Reset),
        .clr   (state_q != LAUNCH),
        .en    (state_q == LAUNCH),
        .limit (16'(START_CYCLES)),
        .count (launch_count),
        .last  (launch_last)
    );

    sat_counter u_run_cnt (
        .clk   (CLK),
        .rst   (Reset),
        .clr   (state_q != RUN),
        .en    (state_q == RUN),
        .limit (TIMEOUT),
        .count (run_count),
        .last  (run_last)
    );

    always_comb begin
        state_d       = state_q;
        prog_idx_d    = prog_idx_q;
        cycle_count_d = cycle_count_q;
        count_valid_d = 1'b0;
        all_done_d    = all_done_q;
        timed_out_d   = timed_out_q;
        case (state_q)
            IDLE, FINISH, ERR: begin
                if (Go) begin
                    state_d     = LAUNCH;
                    prog_idx_d  = '0;
                    all_done_d  = 1'b0;
                    timed_out_d = 1'b0;
                end
            end
            LAUNCH: if (launch_last) state_d = SETTLE;
            // PC can still read all-ones here, so CoreDone is not looked at.
            SETTLE: state_d = RUN;
            RUN: begin
                if (CoreDone) begin
                    cycle_count_d = run_count + 16'd1;
                    count_valid_d = 1'b1;
                    if (prog_idx_q == LAST_IDX) begin
                        state_d    = FINISH;
                        all_done_d = 1'b1;
                    end else begin
                        prog_idx_d = prog_idx_q + 1'b1;
                        state_d    = LAUNCH;
                    end
                end else if (run_last) begin
                    timed_out_d = 1'b1;
                    state_d     = ERR;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered copies of the next-state decode.
        start_d      = (state_d == LAUNCH);
        busy_d       = !(state_d inside {IDLE, FINISH, ERR});
        start_addr_d = START_ADDRS[PIMP_ADDR_W*int'(prog_idx_d) +: PIMP_ADDR_W];
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            prog_idx_q    <= '0;
            cycle_count_q <= '0;
            count_valid_q <= 1'b0;
            all_done_q    <= 1'b0;
            timed_out_q   <= 1'b0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            start_addr_q  <= START_ADDRS[PIMP_ADDR_W-1:0];
        end else begin
            state_q       <= state_d;
            prog_idx_q    <= prog_idx_d;
            cycle_count_q <= cycle_count_d;
            count_valid_q <= count_valid_d;
            all_done_q    <= all_done_d;
            timed_out_q   <= timed_out_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
            start_addr_q  <= start_addr_d;
        end
    end

    assign Start      = start_q;
    assign StartAddr  = start_addr_q;
    assign Busy       = busy_q;
    assign ProgIdx    = prog_idx_q;
    assign CycleCount = cycle_count_q;
    assign CountValid = count_valid_q;
    assign AllDone    = all_done_q;
    assign TimedOut   = timed_out_q;
endmodule
